// File: rtl/uart_hex_scan_display.sv
// Two-digit multiplexed hex display of the last byte received from a UART.
// Optional RX-activity decimal-point flash is enabled by defining DISP_RX_FLASH_EN.
module uart_hex_scan_display #(
  parameter int CLKS_PER_DIGIT = 1200,
  parameter int BLANK_CLKS     = 16,
  parameter int FLASH_CLKS     = 1200000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic [2:0] o_Digit_En,
  output logic [6:0] o_Segment_N,
  output logic       o_Segment_DP_N
);

  typedef enum logic [1:0] {
    SCAN_LO,
    BLANK_A,
    SCAN_HI,
    BLANK_B
  } state_t;

  localparam logic [15:0] SCAN_LAST  = 16'(CLKS_PER_DIGIT - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_CLKS == 0) ? 16'd0 : 16'(BLANK_CLKS - 1);
  localparam bit          SKIP_BLANK = (BLANK_CLKS == 0);

  // Active-low {G,F,E,D,C,B,A} glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  state_t      state;
  state_t      next_state;
  state_t      entry_state;
  logic [15:0] phase_cnt;
  logic [15:0] phase_last;
  logic        running;
  logic        enter;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes the digit snapshot see the
  // old byte when a strobe lands on a scan entry cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Byte <= 8'h00;
    end else if (i_RX_DV) begin
      o_Byte <= i_RX_Byte;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    phase_last = SCAN_LAST;
    next_state = SCAN_LO;
    case (state)
      SCAN_LO: begin
        phase_last = SCAN_LAST;
        next_state = SKIP_BLANK ? SCAN_HI : BLANK_A;
      end
      BLANK_A: begin
        phase_last = BLANK_LAST;
        next_state = SCAN_HI;
      end
      SCAN_HI: begin
        phase_last = SCAN_LAST;
        next_state = SKIP_BLANK ? SCAN_LO : BLANK_B;
      end
      default: begin
        phase_last = BLANK_LAST;
        next_state = SCAN_LO;
      end
    endcase
    // The first clock out of reset is itself an entry into SCAN_LO.
    entry_state = running ? next_state : SCAN_LO;
    enter       = !running || (phase_cnt == phase_last);
  end

  // Segments are loaded only on phase entry, so the registered glyph is the
  // digit snapshot and stays constant for the whole phase.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= SCAN_LO;
      phase_cnt   <= '0;
      running     <= 1'b0;
      o_Digit_En  <= 3'b111;
      o_Segment_N <= 7'h7F;
    end else if (enter) begin
      state     <= entry_state;
      phase_cnt <= '0;
      running   <= 1'b1;
      case (entry_state)
        SCAN_LO: begin
          o_Digit_En  <= 3'b110;
          o_Segment_N <= hex_to_seg(o_Byte[3:0]);
        end
        SCAN_HI: begin
          o_Digit_En  <= 3'b101;
          o_Segment_N <= hex_to_seg(o_Byte[7:4]);
        end
        default: begin
          o_Digit_En  <= 3'b111;
          o_Segment_N <= 7'h7F;
        end
      endcase
    end else begin
      phase_cnt <= phase_cnt + 16'd1;
    end
  end

`ifdef DISP_RX_FLASH_EN
  logic [23:0] flash_cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      flash_cnt <= '0;
    end else if (i_RX_DV) begin
      flash_cnt <= 24'(FLASH_CLKS);
    end else if (flash_cnt != '0) begin
      flash_cnt <= flash_cnt - 24'd1;
    end
  end

  // Built from registers only; a digit is lit exactly in the scan states.
  assign o_Segment_DP_N = ~((flash_cnt != '0) && (o_Digit_En != 3'b111));
`else
  assign o_Segment_DP_N = 1'b1;
`endif

endmodule
